echo_indication_output: RTL and testbench
=========================================

ECHO_INDICATION_OUTPUT -- requirements
Module: echo_indication_output

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, minimum 2.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 indication$heard__ENA  input  1  heard call strobe.
REQ-005 indication$heard$meth  input  32  heard method argument.
REQ-006 indication$heard$v  input  32  heard value argument.
REQ-007 indication$heard__RDY  output  1  heard call accepted when ENA & RDY.
REQ-008 indication$heard2__ENA  input  1  heard2 call strobe.
REQ-009 indication$heard2$meth  input  32  heard2 method argument.
REQ-010 indication$heard2$v  input  32  heard2 value argument.
REQ-011 indication$heard2__RDY  output  1  heard2 call accepted when ENA & RDY.
REQ-012 pipe$enq__ENA  output  1  message valid toward pipe.
REQ-013 pipe$enq$v  output  192  packed message.
REQ-014 pipe$enq__RDY  input  1  pipe accepts message when ENA & RDY.

Function
REQ-015 Message layout: [31:0] tag (1=heard, 2=heard2); [63:32] heard meth; [95:64] heard v; [127:96] heard2 meth; [159:128] heard2 v; [191:160] sequence field; fields unused by the tag are zero.
REQ-016 Accepted calls are packed and written into a DEPTH-entry FIFO with occupancy count 0..DEPTH.
REQ-017 Both RDY outputs = (count <= DEPTH-2), registered-state only, with no combinational path from any ENA.
REQ-018 Both calls accepted in one cycle: heard written first, heard2 second; count += 2.
REQ-019 ENA while RDY low is ignored: no write, no state change.
REQ-020 pipe$enq__ENA = (count != 0); pipe$enq$v = head entry, else all zero when empty.
REQ-021 Dequeue on pipe$enq__ENA & pipe$enq__RDY; head advances one entry.
REQ-022 Simultaneous enqueue(s) and dequeue in one cycle: count updates by writes minus one; order preserved.
REQ-023 Latency: message visible on pipe$enq$v the cycle after acceptance when FIFO was empty.
REQ-024 Read/write pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-025 Output stable: pipe$enq$v and ENA unchanged while ENA=1 and RDY=0.

Reset
REQ-026 nRST low asynchronously clears pointers, count, and sequence counter; pipe$enq__ENA=0, pipe$enq$v=0, both RDY=1 while held (DEPTH>=2).
REQ-027 Reset mid-operation discards all FIFO contents; no partial message is emitted after release.
REQ-028 First accepted call after release is processed normally on the next rising edge.

Configuration
REQ-029 Macro ECHO_INDICATION_SEQNUM_EN defined: 32-bit sequence counter, reset 0, stamped into [191:160] of each accepted message in acceptance order (heard before heard2 in one cycle: n, n+1), incremented per message, wraps 0xFFFFFFFF -> 0.
REQ-030 Macro undefined: no sequence counter; [191:160] always zero.

Verification
REQ-031 Reset, single heard(meth=0x11, v=0xAA), pipe RDY=1 -> next cycle ENA=1, v tag=1, [63:32]=0x11, [95:64]=0xAA, rest zero; dequeued same cycle.
REQ-032 heard(0x1,0x2) and heard2(0x3,0x4) same cycle -> two messages in order, tag 1 then tag 2; heard2 fields in [127:96]=0x3, [159:128]=0x4.
REQ-033 pipe RDY=0, DEPTH=4, issue heard calls -> RDY drops when count=3; exactly 3 accepted; head stable; releasing RDY drains 3 messages in order.
REQ-034 Assert nRST low with 2 queued messages -> ENA=0 immediately; after release no stale message appears.
REQ-035 With ECHO_INDICATION_SEQNUM_EN, 5 calls -> [191:160] = 0,1,2,3,4; force counter to 0xFFFFFFFF -> next two stamps 0xFFFFFFFF, 0x0.
REQ-036 Continuous 1 call/cycle with pipe RDY=1 for 20 cycles -> 20 messages, no RDY deassertion, no reordering.

Source files
------------

// File: rtl/echo_indication_output.sv
// rtl/echo_indication_output.sv - packs heard/heard2 indication calls into a DEPTH-entry message FIFO toward pipe; optional ECHO_INDICATION_SEQNUM_EN stamps a sequence number
module echo_indication_output #(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         indication_heard__ENA,
    input  logic [31:0]  indication_heard_meth,
    input  logic [31:0]  indication_heard_v,
    output logic         indication_heard__RDY,
    input  logic         indication_heard2__ENA,
    input  logic [31:0]  indication_heard2_meth,
    input  logic [31:0]  indication_heard2_v,
    output logic         indication_heard2__RDY,
    output logic         pipe_enq__ENA,
    output logic [191:0] pipe_enq_v,
    input  logic         pipe_enq__RDY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    // Two slots must be free so a same-cycle heard+heard2 pair always fits.
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);

    logic [191:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          rdy;
    logic          acc_h, acc_h2, deq;
    logic [31:0]   seq_h, seq_h2;
    logic [191:0]  msg_h, msg_h2;
    logic [AW-1:0] wr_idx_h2;

    assign rdy = (count_q <= RDY_MAX);
    assign indication_heard__RDY  = rdy;
    assign indication_heard2__RDY = rdy;

    assign pipe_enq__ENA = (count_q != '0);
    assign pipe_enq_v    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

`ifdef ECHO_INDICATION_SEQNUM_EN
    logic [31:0] seq_q, seq_d;

    // Stamps follow acceptance order: heard takes n, heard2 takes n or n+1.
    always_comb begin
        seq_h  = seq_q;
        seq_h2 = seq_q + 32'(acc_h);
        seq_d  = seq_q + 32'(acc_h) + 32'(acc_h2);
    end

    // Sequence counter register; wraps naturally at 32 bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end
`else
    assign seq_h  = '0;
    assign seq_h2 = '0;
`endif

    // Accept/dequeue decisions, message packing and pointer/count next state.
    always_comb begin
        acc_h     = indication_heard__ENA & rdy;
        acc_h2    = indication_heard2__ENA & rdy;
        deq       = (count_q != '0) & pipe_enq__RDY;
        msg_h     = {seq_h, 32'd0, 32'd0, indication_heard_v, indication_heard_meth, 32'd1};
        msg_h2    = {seq_h2, indication_heard2_v, indication_heard2_meth, 32'd0, 32'd0, 32'd2};
        wr_idx_h2 = wr_ptr_q + AW'(acc_h);
        wr_ptr_d  = wr_ptr_q + AW'(acc_h) + AW'(acc_h2);
        rd_ptr_d  = rd_ptr_q + AW'(deq);
        count_d   = count_q + CW'(acc_h) + CW'(acc_h2) - CW'(deq);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents past the read pointer are unreachable after reset.
    always_ff @(posedge CLK) begin
        if (acc_h) begin
            mem_q[wr_ptr_q] <= msg_h;
        end
        if (acc_h2) begin
            mem_q[wr_idx_h2] <= msg_h2;
        end
    end

endmodule

// File: tb/tb_echo_indication_output.sv
// tb/tb_echo_indication_output.sv - table-driven and scoreboard bench for echo_indication_output
module tb_echo_indication_output;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic         h_ena, h2_ena, p_rdy;
    logic [31:0]  h_meth, h_v, h2_meth, h2_v;
    logic         h_rdy, h2_rdy, p_ena;
    logic [191:0] p_v;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;

    logic [191:0] sb_q[$];
    int           m_count  = 0;
    logic [31:0]  m_seq    = 0;

    typedef struct {
        logic        he;
        logic [31:0] hm;
        logic [31:0] hv;
        logic        h2e;
        logic [31:0] h2m;
        logic [31:0] h2v;
        logic        prdy;
        logic        exp_rdy;
        logic        exp_ena;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    echo_indication_output #(.DEPTH(DEPTH)) dut (
        .CLK                    (clk),
        .nRST                   (nrst),
        .indication_heard__ENA  (h_ena),
        .indication_heard_meth  (h_meth),
        .indication_heard_v     (h_v),
        .indication_heard__RDY  (h_rdy),
        .indication_heard2__ENA (h2_ena),
        .indication_heard2_meth (h2_meth),
        .indication_heard2_v    (h2_v),
        .indication_heard2__RDY (h2_rdy),
        .pipe_enq__ENA          (p_ena),
        .pipe_enq_v             (p_v),
        .pipe_enq__RDY          (p_rdy)
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] mk(input logic [31:0] tag, input logic [31:0] hm, input logic [31:0] hv,
                                        input logic [31:0] h2m, input logic [31:0] h2v, input logic [31:0] seq);
`ifdef ECHO_INDICATION_SEQNUM_EN
        return {seq, h2v, h2m, hv, hm, tag};
`else
        return {32'd0, h2v, h2m, hv, hm, tag};
`endif
    endfunction

    // One cycle: drive inputs, check outputs against the model, then advance the model across the edge.
    task automatic step(input logic he, input logic [31:0] hm, input logic [31:0] hv,
                        input logic h2e, input logic [31:0] h2m, input logic [31:0] h2v, input logic prdy);
        logic mrdy, acc1, acc2;
        logic [191:0] head;
        h_ena = he; h_meth = hm; h_v = hv;
        h2_ena = h2e; h2_meth = h2m; h2_v = h2v;
        p_rdy = prdy;
        #1;
        mrdy = (m_count <= DEPTH - 2);
        head = (sb_q.size() != 0) ? sb_q[0] : '0;
        check("heard_rdy", {191'd0, h_rdy}, {191'd0, mrdy});
        check("heard2_rdy", {191'd0, h2_rdy}, {191'd0, mrdy});
        check("pipe_ena", {191'd0, p_ena}, {191'd0, (m_count != 0)});
        check("pipe_v", p_v, head);
        acc1 = he & mrdy;
        acc2 = h2e & mrdy;
        if (m_count != 0 && prdy) begin
            void'(sb_q.pop_front());
            m_count--;
        end
        if (acc1) begin
            sb_q.push_back(mk(32'd1, hm, hv, 32'd0, 32'd0, m_seq));
            m_seq++;
            m_count++;
        end
        if (acc2) begin
            sb_q.push_back(mk(32'd2, 32'd0, 32'd0, h2m, h2v, m_seq));
            m_seq++;
            m_count++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic prdy);
        step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, prdy);
    endtask

    initial begin
        nrst = 1'b0;
        h_ena = 0; h_meth = 0; h_v = 0; h2_ena = 0; h2_meth = 0; h2_v = 0; p_rdy = 0;

        vecs[0]  = '{1, 32'h11, 32'hAA, 0, 0, 0, 1, 1, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[2]  = '{1, 32'h1, 32'h2, 1, 32'h3, 32'h4, 0, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[4]  = '{1, 32'h5, 32'h6, 0, 0, 0, 0, 1, 1};
        vecs[5]  = '{1, 32'h7, 32'h8, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 32'h9, 32'hA, 1, 0, 1};
        vecs[7]  = '{1, 32'hB, 32'hC, 1, 32'hD, 32'hE, 1, 1, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};

        @(negedge clk);
        @(negedge clk);
        check("reset_ena", {191'd0, p_ena}, 192'd0);
        check("reset_v", p_v, 192'd0);
        check("reset_rdy", {190'd0, h_rdy, h2_rdy}, 192'd3);
        nrst = 1'b1;
        @(negedge clk);

        // Table: single call, pair ordering, fill to threshold, ignored calls, mixed enq/deq, drain.
        for (int i = 0; i < 12; i++) begin
            h_ena = vecs[i].he; p_rdy = vecs[i].prdy;
            #1;
            check($sformatf("vec%0d_rdy", i), {191'd0, h_rdy}, {191'd0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_ena", i), {191'd0, p_ena}, {191'd0, vecs[i].exp_ena});
            step(vecs[i].he, vecs[i].hm, vecs[i].hv, vecs[i].h2e, vecs[i].h2m, vecs[i].h2v, vecs[i].prdy);
        end

        // Backpressure: only three heard calls fit, head held, then ordered drain.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h100 + i, 32'h200 + i, 1'b0, 0, 0, 1'b0);
        check("bp_count", 192'(m_count), 192'd3);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Reset with queued messages: output clears immediately, nothing stale after release.
        step(1'b1, 32'h31, 32'h32, 1'b1, 32'h33, 32'h34, 1'b0);
        nrst = 1'b0;
        #1;
        check("midrst_ena", {191'd0, p_ena}, 192'd0);
        check("midrst_v", p_v, 192'd0);
        check("midrst_rdy", {191'd0, h_rdy}, 192'd1);
        sb_q.delete();
        m_count = 0;
        m_seq = 0;
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Streaming one call per cycle with the pipe always ready.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(1'b1, 32'h400 + i, 32'h500 + i, 1'b0, 0, 0, 1'b1);
            else            step(1'b0, 0, 0, 1'b1, 32'h600 + i, 32'h700 + i, 1'b1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

`ifdef ECHO_INDICATION_SEQNUM_EN
        // Counter wrap: stamps FFFFFFFF then 0 for a same-cycle pair.
        force dut.seq_q = 32'hFFFF_FFFF;
        #1;
        release dut.seq_q;
        m_seq = 32'hFFFF_FFFF;
        step(1'b1, 32'h51, 32'h52, 1'b1, 32'h53, 32'h54, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
`endif

        check("final_empty", 192'(sb_q.size()), 192'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
